// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state and result record for the adder arbiter.
package adder_arb_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    localparam int W_DEF = 64;
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF = $clog2(NREQ_DEF);
    typedef struct packed {
        logic [IDW_DEF-1:0] id;
        logic [W_DEF-1:0]   sum;
        logic               cout;
        logic               last;
    } result_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set req at or above ptr with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    assign any = |req;
    // Scan farthest-first so the nearest requester from ptr wins.
    always_comb begin
        idx = ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[IDW'((int'(ptr) + i) % NREQ)]) idx = IDW'((int'(ptr) + i) % NREQ);
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: burst-granular round-robin sharing of one registered add-with-carry
// datapath; carry chains limb to limb within a burst.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int W = 64,
    parameter int NREQ = 4,
    parameter int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_last,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_last
);
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   sum;
        logic           cout;
        logic           last;
    } rsp_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr, gnt_id, pick_idx;
    logic           pick_any, c_chain, first, go, accept, cin;
    logic [W:0]     total;
    rsp_t           rsp;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req(req_valid),
        .ptr(rr_ptr),
        .idx(pick_idx),
        .any(pick_any)
    );

    assign go = !rsp_valid || rsp_ready;
    assign accept = state == BURST && req_valid[gnt_id] && go;
    assign cin = first ? req_cin[gnt_id] : c_chain;
    assign total = {1'b0, req_a[gnt_id*W +: W]} + {1'b0, req_b[gnt_id*W +: W]} + {{W{1'b0}}, cin};
    assign req_ready = (state == BURST && go) ? NREQ'(1) << gnt_id : '0;
    assign {rsp_id, rsp_sum, rsp_cout, rsp_last} = rsp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            c_chain   <= 1'b0;
            first     <= 1'b1;
            rsp       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (accept) begin
                rsp       <= '{id: gnt_id, sum: total[W-1:0], cout: total[W], last: req_last[gnt_id]};
                rsp_valid <= 1'b1;
                c_chain   <= total[W];
                first     <= 1'b0;
                if (req_last[gnt_id]) begin
                    rr_ptr <= gnt_id == IDW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
                    state  <= IDLE;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // IDLE is the one bubble cycle between bursts: pick the next owner.
            if (state == IDLE && pick_any) begin
                gnt_id <= pick_idx;
                first  <= 1'b1;
                state  <= BURST;
            end
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random bursts checked against a multi-word
// arithmetic model of each burst.
module tb_adder_arbiter;
    localparam int W = 64;
    localparam int NREQ = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0, req_cin = '0, req_last = '0, req_ready;
    logic [NREQ*W-1:0] req_a = '0, req_b = '0;
    logic              rsp_valid, rsp_cout, rsp_last;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;

    typedef struct {logic [W-1:0] a, b; logic cin, last;} beat_t;
    typedef struct {logic [W-1:0] sum; logic cout, last;} exp_t;

    beat_t           bq[NREQ][$];
    exp_t            eq[NREQ][$];
    int              seen[$];
    int              rt[$];
    logic [NREQ-1:0] hold = '0;
    int              vectors = 0, miscompares = 0, cyc = 0;

    adder_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd64();
        return ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
    endfunction

    // A burst is one wide add of the concatenated limbs; each limb's carry-out
    // is the carry across that limb boundary of the wide sum.
    task automatic push_burst(input int id, input int n, input logic [3*W-1:0] a,
                              input logic [3*W-1:0] b, input logic cin);
        logic [4*W-1:0] wa, wb, m, p;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        for (int k = 0; k < n; k++) begin
            m = '1;
            m = m >> (W * (3 - k));
            p = (wa & m) + (wb & m) + (4 * W)'(cin);
            eq[id].push_back('{p[k*W +: W], p[(k+1)*W], k == n - 1});
            bq[id].push_back('{a[k*W +: W], b[k*W +: W], k == 0 ? cin : 1'($urandom), k == n - 1});
        end
    endtask

    function automatic bit quiet();
        bit q = !rsp_valid;
        for (int i = 0; i < NREQ; i++) q &= bq[i].size() == 0 && eq[i].size() == 0;
        return q;
    endfunction

    task automatic drain(input string tag, input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = quiet();
        end
        chk({tag, "_drain"}, 64'(done), 64'(1));
    endtask

    task automatic wait_rsp(input string tag, input int id);
        bit got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = rsp_valid && rsp_id == IDW'(id);
        end
        chk({tag, "_seen"}, 64'(got), 64'(1));
    endtask

    // Requester drivers and response monitor.
    initial begin
        logic [NREQ-1:0] fire;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            fire = req_valid & req_ready;
            if (rsp_valid && rsp_ready) begin
                seen.push_back(int'(rsp_id));
                rt.push_back(cyc);
                chk("rsp_pending", 64'(eq[rsp_id].size() != 0), 64'(1));
                if (eq[rsp_id].size() != 0) begin
                    e = eq[rsp_id].pop_front();
                    chk("rsp_sum", rsp_sum, e.sum);
                    chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                    chk("rsp_last", 64'(rsp_last), 64'(e.last));
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i] && bq[i].size() != 0) void'(bq[i].pop_front());
                req_valid[i] = bq[i].size() != 0 && !hold[i];
                if (bq[i].size() != 0) begin
                    req_a[i*W +: W] = bq[i][0].a;
                    req_b[i*W +: W] = bq[i][0].b;
                    req_cin[i]      = bq[i][0].cin;
                    req_last[i]     = bq[i][0].last;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        logic [W-1:0] snap_sum;
        logic [IDW+2:0] snap_ctl;
        // Reset, with every requester already asking for two single-beat bursts.
        for (int i = 0; i < NREQ; i++)
            for (int r = 0; r < 2; r++) push_burst(i, 1, {3{rnd64()}}, {3{rnd64()}}, 1'($urandom));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_sum", rsp_sum, 64'(0));
        chk("rst_cout", 64'(rsp_cout), 64'(0));
        chk("rst_id", 64'(rsp_id), 64'(0));
        chk("rst_last", 64'(rsp_last), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1 resetn = 1'b1;
        // Fairness: order 0,1,2,3,0,... with one bubble between grants.
        drain("rr", 200);
        for (int k = 0; k < 8; k++) begin
            chk("rr_order", 64'(seen.size() > k ? seen[k] : -1), 64'(k % NREQ));
            if (k > 0) chk("rr_gap", 64'(rt.size() > k ? rt[k] - rt[k-1] : -1), 64'(2));
        end
        // Single beat on requester 0: latency and wrap to zero with carry out.
        seen.delete();
        push_burst(0, 1, {128'd0, 64'hFFFF_FFFF_FFFF_FFFF}, {128'd0, 64'd1}, 1'b0);
        t0 = -1;
        t1 = -1;
        for (int c = 0; c < 40 && t1 < 0; c++) begin
            @(negedge clk);
            if (t0 < 0 && req_valid[0]) t0 = c;
            if (rsp_valid) t1 = c;
        end
        chk("single_latency", 64'(t1 - t0), 64'(2));
        chk("single_sum", rsp_sum, 64'(0));
        chk("single_cout", 64'(rsp_cout), 64'(1));
        drain("single", 100);
        chk("single_id", 64'(seen.size() == 1 ? seen[0] : -1), 64'(0));
        // Two-limb carry chain on requester 2: sums 0 then 13.
        push_burst(2, 2, {64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd0, 64'd7, 64'd0}, 1'b1);
        wait_rsp("chain0", 2);
        chk("chain0_sum", rsp_sum, 64'(0));
        chk("chain0_cout", 64'(rsp_cout), 64'(1));
        @(negedge clk);
        chk("chain1_sum", rsp_sum, 64'd13);
        chk("chain1_cout", 64'(rsp_cout), 64'(0));
        drain("chain", 100);
        // Back-pressure for three cycles during a three-limb burst.
        push_burst(1, 3, {rnd64(), rnd64(), rnd64()}, {rnd64(), rnd64(), rnd64()}, 1'($urandom));
        wait_rsp("bp", 1);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid", 64'(rsp_valid), 64'(1));
        chk("bp_ready0", 64'(req_ready), 64'(0));
        snap_sum = rsp_sum;
        snap_ctl = {rsp_valid, rsp_id, rsp_cout, rsp_last};
        repeat (2) begin
            @(negedge clk);
            chk("bp_hold_sum", rsp_sum, snap_sum);
            chk("bp_hold_ctl", 64'({rsp_valid, rsp_id, rsp_cout, rsp_last}), 64'(snap_ctl));
            chk("bp_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain("bp", 100);
        // Grant hold: requester 1 goes quiet mid-burst while requester 3 waits.
        seen.delete();
        push_burst(1, 3, {rnd64(), rnd64(), rnd64()}, {rnd64(), rnd64(), rnd64()}, 1'($urandom));
        wait_rsp("hold", 1);
        hold[1] = 1'b1;
        push_burst(3, 1, {3{rnd64()}}, {3{rnd64()}}, 1'($urandom));
        repeat (4) begin
            @(negedge clk);
            chk("hold_ready3", 64'(req_ready[3]), 64'(0));
        end
        hold[1] = 1'b0;
        drain("hold", 100);
        chk("hold_count", 64'(seen.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk("hold_order", 64'(seen.size() > k ? seen[k] : -1), 64'(k < 3 ? 1 : 3));
        // Reset after beat 0 of a burst that leaves a carry of 1 in the chain.
        push_burst(2, 2, {64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd0, 64'd7, 64'd1}, 1'b0);
        wait_rsp("rstmid", 2);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", 64'(rsp_valid), 64'(0));
        chk("rstmid_sum", rsp_sum, 64'(0));
        chk("rstmid_ctl", 64'({rsp_id, rsp_cout, rsp_last}), 64'(0));
        chk("rstmid_ready", 64'(req_ready), 64'(0));
        eq[2].delete();
        bq[2].delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        seen.delete();
        push_burst(3, 1, {3{rnd64()}}, {3{rnd64()}}, 1'b1);
        push_burst(1, 1, {128'd0, 64'd5}, {128'd0, 64'd7}, 1'b0);
        wait_rsp("rstmid_next", 1);
        chk("rstmid_next_sum", rsp_sum, 64'd12);
        drain("rstmid", 100);
        chk("rstmid_order", 64'(seen.size() == 2 ? seen[0] * 4 + seen[1] : -1), 64'(1 * 4 + 3));
        // Random bursts with random response back-pressure.
        for (int r = 0; r < 24; r++)
            push_burst($urandom_range(0, NREQ - 1), $urandom_range(1, 3),
                       {rnd64(), rnd64(), rnd64()}, {rnd64(), rnd64(), rnd64()}, 1'($urandom));
        for (int c = 0; c < 3000 && !quiet(); c++) begin
            @(posedge clk);
            #1 rsp_ready = $urandom_range(0, 3) != 0;
        end
        rsp_ready = 1'b1;
        drain("rand", 200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
